gf2_syndrome_decoder: RTL and testbench
=======================================

# gf2_syndrome_decoder

Receive-side counterpart of the GF(2) matrix-product block. It accepts an N-bit received codeword, computes the R-bit syndrome s = H·w (mod 2) serially, one parity-check column per cycle. It then searches H for a column equal to s and corrects the single-bit error if one exists. It sits between the channel/receive buffer and the data consumer, and uses valid/ready handshakes on both sides.

## Interface

- N, 8, codeword length in bits (≥2)
- R, 4, syndrome width = number of parity-check rows (≥2)
- H, 32'h8FED_CBA9, parity-check matrix packed column-major as [N-1:0][R-1:0]; column j = H[j]. Default is extended Hamming(8,4): columns 0..7 = 9,A,B,C,D,E,F,8. Columns must be distinct and nonzero.
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept a word; high only in IDLE and while rst is low
- in_data  in  N  received codeword
- out_valid  out  1  result is valid; held until out_ready
- out_ready  in  1  consumer accepts the result
- out_data  out  N  corrected word; unchanged input word if the error is uncorrectable
- out_syndrome  out  R  computed syndrome
- out_err  out  1  single-bit error detected and corrected
- out_uncorr  out  1  nonzero syndrome that matches no column of H

## Operation

- FSM states: IDLE, SYND, SRCH, DONE. Registers: word[N-1:0], syn[R-1:0], idx (clog2(N) bits), hit, pos.
- IDLE: in_ready=1. On in_valid && in_ready:
  - word ← in_data, syn ← 0, idx ← 0, hit ← 0.
  - Go to SYND.
- SYND, one column per cycle:
  - syn ← syn ^ (word[idx] ? H[idx] : 0).
  - When idx==N-1: idx ← 0 and go to SRCH. Otherwise idx ← idx+1.
- SRCH, one column per cycle:
  - If !hit && syn!=0 && syn==H[idx]: hit ← 1, pos ← idx. Lowest matching index wins.
  - When idx==N-1, load the output registers and go to DONE.
  - The search always runs N cycles, even when syn==0, so latency is fixed.
- Output load:
  - out_syndrome ← syn.
  - syn==0: out_data ← word, out_err ← 0, out_uncorr ← 0.
  - Match found: out_data ← word with bit pos inverted, out_err ← 1, out_uncorr ← 0.
  - No match: out_data ← word, out_err ← 0, out_uncorr ← 1.
  - The match decision on the final SRCH cycle includes the comparison for column N-1.
- DONE: out_valid=1 and all out_* stay stable. On out_ready, out_valid ← 0 and the FSM goes to IDLE.
- Arithmetic is pure XOR/AND; there is no carry. idx never exceeds N-1.
- in_data is ignored outside IDLE. in_valid asserted during SYND/SRCH/DONE is not consumed.

## Timing

- Reset, applied on any clk edge with rst=1:
  - State goes to IDLE. out_valid, out_err, out_uncorr go to 0. out_data and out_syndrome go to 0. syn, idx, hit, pos are cleared.
  - in_ready is 0 while rst=1 and 1 from the first cycle with rst=0.
- Reset mid-operation (SYND, SRCH or DONE): the word in flight is discarded, no output is produced, and the FSM returns to IDLE.
- Latency, with the accept edge as edge 0:
  - SYND spans edges 1..N. SRCH spans edges N+1..2N.
  - out_valid is high after edge 2N (edge 16 for N=8).
- out_ready high while out_valid is high: the result is consumed on that edge and in_ready is high in the next cycle.
- Minimum word period is 2N+2 cycles. There is no overlap between words.
- Back-pressure: out_ready low holds DONE indefinitely with outputs unchanged.

## Test plan

- Clean codeword, default H: in_data=8'h87 → after 16 edges out_valid=1, out_syndrome=4'h0, out_data=8'h87, out_err=0, out_uncorr=0.
- Single error, sweep bit j=0..7 on base 8'h87 (e.g. 8'h97, bit 4) → out_syndrome=H[j] (4'hD for bit 4), out_data=8'h87, out_err=1.
- Double error: in_data=8'h84 (bits 0,1 flipped) → out_syndrome=4'h3, out_uncorr=1, out_err=0, out_data=8'h84.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0 throughout. Release → one transfer, then in_ready=1 next cycle.
- Reset mid-SRCH: assert rst for one cycle at edge 12 → out_valid never rises for that word. The next word 8'h00 yields out_syndrome=0 and out_data=8'h00 with normal latency.
- Back-to-back: in_valid held high with words 8'h87, 8'h97, 8'h84 and out_ready=1 → results in order, each accepted 2N+2=18 cycles after the previous accept.

Source files
------------

// File: rtl/gf2_syndrome_decoder.sv
// Serial GF(2) syndrome decoder: accumulates s = H*w one column per cycle,
// then scans H for a column equal to s and flips that bit (single-error correction).
module gf2_syndrome_decoder #(
  parameter int N = 8,
  parameter int R = 4,
  parameter logic [N-1:0][R-1:0] H = 32'h8FED_CBA9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [R-1:0] out_syndrome,
  output logic         out_err,
  output logic         out_uncorr
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, SYND, SRCH, DONE} state_t;

  state_t        state, state_d;
  logic [N-1:0]  word;
  logic [R-1:0]  syn;
  logic [IW-1:0] idx;
  logic [IW-1:0] pos;
  logic          hit;

  logic          match, hit_d;
  logic [IW-1:0] pos_d;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  // Lowest matching column wins: once hit is set, later matches are ignored.
  assign match = (syn != '0) && (syn == H[idx]);
  assign hit_d = hit | match;
  assign pos_d = hit ? pos : idx;

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (in_valid) state_d = SYND;
      SYND: if (idx == LAST) state_d = SRCH;
      SRCH: if (idx == LAST) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word         <= '0;
      syn          <= '0;
      idx          <= '0;
      pos          <= '0;
      hit          <= 1'b0;
      out_data     <= '0;
      out_syndrome <= '0;
      out_err      <= 1'b0;
      out_uncorr   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          word <= in_data;
          syn  <= '0;
          idx  <= '0;
          hit  <= 1'b0;
        end
        SYND: begin
          if (word[idx]) syn <= syn ^ H[idx];
          idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        SRCH: begin
          hit <= hit_d;
          pos <= pos_d;
          idx <= (idx == LAST) ? '0 : idx + 1'b1;
          // Search runs the full N cycles regardless of syn, so latency is fixed.
          if (idx == LAST) begin
            out_syndrome <= syn;
            if (syn == '0) begin
              out_data   <= word;
              out_err    <= 1'b0;
              out_uncorr <= 1'b0;
            end else if (hit_d) begin
              out_data   <= word ^ (N'(1) << pos_d);
              out_err    <= 1'b1;
              out_uncorr <= 1'b0;
            end else begin
              out_data   <= word;
              out_err    <= 1'b0;
              out_uncorr <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_syndrome_decoder.sv
// Directed bench for gf2_syndrome_decoder with default extended Hamming(8,4) H.
module tb_gf2_syndrome_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [3:0] out_syndrome;
  logic       out_err, out_uncorr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gf2_syndrome_decoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_syndrome(out_syndrome), .out_err(out_err), .out_uncorr(out_uncorr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept one word, measure latency to out_valid, check result and hand-off.
  task automatic run_word(input string tag, input logic [7:0] d, input logic [7:0] ed,
                          input logic [3:0] es, input logic ee, input logic eu);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 40) begin @(posedge clk); #1; cnt++; end
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'hxx;
    cnt = 0;
    while (cnt < 40) begin
      @(posedge clk); #1; cnt++;
      if (out_valid) break;
    end
    chk({tag, "_lat"}, cnt, 16);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_syn"}, out_syndrome, es);
    chk({tag, "_err"}, out_err, ee);
    chk({tag, "_unc"}, out_uncorr, eu);
    @(posedge clk); #1;
    chk({tag, "_rel"}, {out_valid, in_ready}, 2'b01);
  endtask

  localparam logic [3:0] COL [8] = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h8};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_outs", {out_valid, out_err, out_uncorr, out_data, out_syndrome}, '0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1'b1);

    run_word("clean", 8'h87, 8'h87, 4'h0, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      logic [7:0] bad;
      bad = 8'h87 ^ (8'h01 << j);
      run_word($sformatf("single%0d", j), bad, 8'h87, COL[j], 1'b1, 1'b0);
    end
    run_word("double", 8'h84, 8'h84, 4'h3, 1'b0, 1'b1);

    // Back-pressure: hold DONE for 10 cycles.
    begin
      int cnt;
      in_valid = 1'b1; in_data = 8'h97; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 40) begin @(posedge clk); #1; cnt++; end
      chk("bp_lat", cnt, 16);
      for (int k = 0; k < 10; k++) begin
        chk("bp_hold", {out_valid, in_ready, out_data, out_syndrome, out_err, out_uncorr},
            {1'b1, 1'b0, 8'h87, 4'hD, 1'b1, 1'b0});
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", {out_valid, in_ready}, 2'b01);
    end

    // Reset during SRCH: accept at edge 0, reset on edge 12.
    begin
      logic seen;
      in_valid = 1'b1; in_data = 8'h97;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      chk("mid_pre", {out_valid, in_ready}, 2'b00);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("mid_idle", in_ready, 1'b1);
      seen = 1'b0;
      repeat (20) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      chk("mid_no_out", seen, 1'b0);
      run_word("after_rst", 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
    end

    // Back-to-back with in_valid held high.
    begin
      logic [7:0] w  [3] = '{8'h87, 8'h97, 8'h84};
      logic [7:0] ed [3] = '{8'h87, 8'h87, 8'h84};
      logic [3:0] es [3] = '{4'h0, 4'hD, 4'h3};
      logic [1:0] ef [3] = '{2'b00, 2'b10, 2'b01};
      int acc_cyc [3];
      int cyc, na, nr;
      logic acc;
      cyc = 0; na = 0; nr = 0;
      in_valid = 1'b1; in_data = w[0]; out_ready = 1'b1;
      for (int t = 0; t < 120 && nr < 3; t++) begin
        acc = in_ready && in_valid;
        if (out_valid) begin
          chk($sformatf("b2b%0d_data", nr), out_data, ed[nr]);
          chk($sformatf("b2b%0d_syn", nr), out_syndrome, es[nr]);
          chk($sformatf("b2b%0d_flags", nr), {out_err, out_uncorr}, ef[nr]);
          nr++;
        end
        @(posedge clk); #1; cyc++;
        if (acc) begin
          acc_cyc[na] = cyc;
          na++;
          if (na < 3) in_data = w[na];
          else        in_valid = 1'b0;
        end
      end
      in_valid = 1'b0;
      chk("b2b_results", nr, 3);
      chk("b2b_accepts", na, 3);
      if (na == 3) begin
        chk("b2b_period1", acc_cyc[1] - acc_cyc[0], 18);
        chk("b2b_period2", acc_cyc[2] - acc_cyc[1], 18);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
